// File: rtl/add_share_ctrl.sv
// Arbiter/sequencer sharing one external multi-cycle ripple adder between PC+4 and branch-target requesters.
// Optional macro ADD_SHARE_RR_EN selects round-robin arbitration; default is fixed priority to requester 0.
module add_share_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0_valid,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   output logic        req0_ready,
   input  logic        req1_valid,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        req1_ready,
   output logic [31:0] add_a,
   output logic [31:0] add_b,
   input  logic [31:0] add_s,
   output logic        resp_valid,
   output logic [31:0] resp_sum,
   output logic        resp_id,
   output logic        busy
);

   typedef enum logic {IDLE, SETTLE} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t      state_reg, state_next;
   logic [3:0]  cnt_reg, cnt_next;
   logic        last_reg, last_next;
   logic        id_reg, id_next;
   logic [31:0] add_a_reg, add_a_next;
   logic [31:0] add_b_reg, add_b_next;
   logic [31:0] resp_sum_reg, resp_sum_next;
   logic        resp_id_reg, resp_id_next;
   logic        resp_valid_reg, resp_valid_next;

   logic        grant;
   logic        accept;

   always_comb begin
`ifdef ADD_SHARE_RR_EN
      // On a tie the requester that was not served last wins.
      if (req0_valid && req1_valid) begin
         grant = ~last_reg;
      end else begin
         grant = req1_valid;
      end
`else
      grant = ~req0_valid;
`endif
   end

   assign req0_ready = (state_reg == IDLE) && !grant && req0_valid;
   assign req1_ready = (state_reg == IDLE) &&  grant && req1_valid;
   assign accept     = req0_ready || req1_ready;

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      last_next       = last_reg;
      id_next         = id_reg;
      add_a_next      = add_a_reg;
      add_b_next      = add_b_reg;
      resp_sum_next   = resp_sum_reg;
      resp_id_next    = resp_id_reg;
      resp_valid_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               add_a_next = grant ? req1_a : req0_a;
               add_b_next = grant ? req1_b : req0_b;
               id_next    = grant;
               last_next  = grant;
               cnt_next   = CNT_LOAD;
               state_next = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt_reg == 4'd0) begin
               resp_sum_next   = add_s;
               resp_id_next    = id_reg;
               resp_valid_next = 1'b1;
               state_next      = IDLE;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         cnt_reg        <= 4'd0;
         last_reg       <= 1'b1;
         id_reg         <= 1'b0;
         add_a_reg      <= 32'd0;
         add_b_reg      <= 32'd0;
         resp_sum_reg   <= 32'd0;
         resp_id_reg    <= 1'b0;
         resp_valid_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         last_reg       <= last_next;
         id_reg         <= id_next;
         add_a_reg      <= add_a_next;
         add_b_reg      <= add_b_next;
         resp_sum_reg   <= resp_sum_next;
         resp_id_reg    <= resp_id_next;
         resp_valid_reg <= resp_valid_next;
      end
   end

   assign add_a      = add_a_reg;
   assign add_b      = add_b_reg;
   assign resp_sum   = resp_sum_reg;
   assign resp_id    = resp_id_reg;
   assign resp_valid = resp_valid_reg;
   assign busy       = (state_reg == SETTLE);

endmodule

// File: tb/tb_add_share_ctrl.sv
// Scoreboard bench for add_share_ctrl: two instances (settle 4 and settle 1) share random stimulus
// and are checked against a cycle-level transaction model.
module tb_add_share_ctrl;

   localparam int S0 = 4;
   localparam int S1 = 1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;

   logic        r0 [2];
   logic        r1 [2];
   logic        bsy [2];
   logic        rv [2];
   logic        rid [2];
   logic [31:0] aa [2];
   logic [31:0] ab [2];
   logic [31:0] rs [2];
   logic [31:0] adds [2];

   always #5 clk = ~clk;

   // External adder stand-in: modulo 2^32 sum of the registered operands.
   assign adds[0] = aa[0] + ab[0];
   assign adds[1] = aa[1] + ab[1];

   add_share_ctrl #(.SETTLE_CYCLES(S0)) u_dut0 (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(r0[0]),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(r1[0]),
      .add_a(aa[0]), .add_b(ab[0]), .add_s(adds[0]),
      .resp_valid(rv[0]), .resp_sum(rs[0]), .resp_id(rid[0]), .busy(bsy[0])
   );

   add_share_ctrl #(.SETTLE_CYCLES(S1)) u_dut1 (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(r0[1]),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(r1[1]),
      .add_a(aa[1]), .add_b(ab[1]), .add_s(adds[1]),
      .resp_valid(rv[1]), .resp_sum(rs[1]), .resp_id(rid[1]), .busy(bsy[1])
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;
   bit run     = 1'b0;

   typedef struct {
      int          inst;
      logic [31:0] sum;
      logic        id;
      int          due;
   } exp_t;
   exp_t sb[$];

   // Transaction model: when each instance is next free, who it served last, what it drives to the adder.
   int          free_at [2] = '{0, 0};
   logic        last_m  [2] = '{1'b1, 1'b1};
   logic [31:0] ea      [2] = '{32'd0, 32'd0};
   logic [31:0] eb      [2] = '{32'd0, 32'd0};
   int          acc_cyc [2] = '{-1, -1};

   function automatic int settle_of(input int i);
      return (i == 0) ? S0 : S1;
   endfunction

   task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d cycle %0d: got 0x%08h, expected 0x%08h", name, inst, cyc, act, exp);
      end
   endtask

   // Who gets the adder: a lone requester always wins; a tie goes to requester 0,
   // or under round-robin to whoever was not served last.
   function automatic logic winner(input logic v0, input logic v1, input logic last);
      if (v0 && !v1) return 1'b0;
      if (v1 && !v0) return 1'b1;
`ifdef ADD_SHARE_RR_EN
      return (last == 1'b0) ? 1'b1 : 1'b0;
`else
      return 1'b0;
`endif
   endfunction

   task automatic step(input logic rst, input logic v0, input logic v1,
                       input logic [31:0] a0, input logic [31:0] b0,
                       input logic [31:0] a1, input logic [31:0] b1);
      logic idle, g, er0, er1;
      @(posedge clk);
      #1;
      reset = rst; req0_valid = v0; req1_valid = v1;
      req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         idle = (cyc >= free_at[i]);
         g    = winner(v0, v1, last_m[i]);
         er0  = idle && (v0 || v1) && !g;
         er1  = idle && (v0 || v1) && g;
         chk("req0_ready", i, {31'd0, r0[i]}, {31'd0, er0});
         chk("req1_ready", i, {31'd0, r1[i]}, {31'd0, er1});
         chk("busy", i, {31'd0, bsy[i]}, {31'd0, !idle});
         chk("add_a", i, aa[i], ea[i]);
         chk("add_b", i, ab[i], eb[i]);
         if (rst) begin
            for (int k = sb.size() - 1; k >= 0; k--)
               if (sb[k].inst == i && sb[k].due > cyc) sb.delete(k);
            free_at[i] = cyc + 1;
            last_m[i]  = 1'b1;
            ea[i]      = 32'd0;
            eb[i]      = 32'd0;
         end else if (er0 || er1) begin
            sb.push_back('{i, g ? (a1 + b1) : (a0 + b0), g, cyc + settle_of(i) + 1});
            free_at[i] = cyc + settle_of(i) + 1;
            last_m[i]  = g;
            ea[i]      = g ? a1 : a0;
            eb[i]      = g ? b1 : b0;
            acc_cyc[i] = cyc;
         end
      end
   endtask

   task automatic chk_resp_zero();
      for (int i = 0; i < 2; i++) begin
         chk("resp_valid_zero", i, {31'd0, rv[i]}, 32'd0);
         chk("resp_sum_zero", i, rs[i], 32'd0);
         chk("resp_id_zero", i, {31'd0, rid[i]}, 32'd0);
      end
   endtask

   // Response monitor: pops the oldest expectation of an instance whenever it pulses resp_valid.
   always @(negedge clk) begin
      if (run) begin
         for (int i = 0; i < 2; i++) begin
            int idx;
            idx = -1;
            for (int k = 0; k < sb.size(); k++)
               if (idx < 0 && sb[k].inst == i) idx = k;
            if (rv[i]) begin
               if (idx < 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL unexpected_resp dut%0d cycle %0d: got sum 0x%08h, expected no response", i, cyc, rs[i]);
               end else begin
                  $display("[TB] dut%0d resp id=%0d sum=0x%08h cycle=%0d", i, rid[i], rs[i], cyc);
                  chk("resp_sum", i, rs[i], sb[idx].sum);
                  chk("resp_id", i, {31'd0, rid[i]}, {31'd0, sb[idx].id});
                  chk("resp_cycle", i, cyc, sb[idx].due);
                  sb.delete(idx);
               end
            end else if (idx >= 0 && sb[idx].due <= cyc) begin
               n_tests++;
               n_fail++;
               $display("FAIL missing_resp dut%0d cycle %0d: got no resp_valid, expected sum 0x%08h", i, cyc, sb[idx].sum);
               sb.delete(idx);
            end
         end
      end
   end

   initial begin
      logic [31:0] x0, y0, x1, y1;
      repeat (2) @(posedge clk);
      run = 1'b1;
      step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
      chk_resp_zero();

      // Single request, held until granted.
      for (int n = 0; n < 3; n++)
         step(1'b0, 1'b1, 1'b0, 32'h0040_0000, 32'd4, 32'd0, 32'd0);
      repeat (6) step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);

      // Contention: both held valid.
      repeat (24) step(1'b0, 1'b1, 1'b1, 32'h100, 32'h4, 32'h100, 32'h20);
      repeat (6) step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);

      // Wrap-around on requester 1.
      for (int n = 0; n < 2; n++)
         step(1'b0, 1'b0, 1'b1, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd8);
      repeat (6) step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);

      // Back-to-back on requester 0 with fresh operands every cycle.
      repeat (24) step(1'b0, 1'b1, 1'b0, $urandom, $urandom, 32'd0, 32'd0);

      // Randomized traffic including drop-before-grant and boundary operands.
      for (int n = 0; n < 300; n++) begin
         x0 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
         y0 = $urandom_range(0, 15);
         x1 = $urandom;
         y1 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
         step(1'b0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0, x0, y0, x1, y1);
      end
      repeat (6) step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);

      // Reset two cycles after an accept on the settle-4 instance.
      acc_cyc[0] = -1;
      for (int n = 0; n < 10 && acc_cyc[0] < 0; n++)
         step(1'b0, 1'b1, 1'b0, 32'h1234_0000, 32'h55, 32'd0, 32'd0);
      step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
      step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
      step(1'b0, 1'b1, 1'b1, 32'h10, 32'h1, 32'h20, 32'h2);
      chk_resp_zero();
      repeat (10) step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);

      chk("scoreboard_empty", 0, sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
